// File: rtl/cnnip_pkg.sv
// Shared helpers for the CNN IP stream blocks: counter/pointer widths and wrap increment.
package cnnip_pkg;

  function automatic int unsigned cnnip_cw(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // A single-entry store still needs a one-bit address port.
  function automatic int unsigned cnnip_pw(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  function automatic int unsigned cnnip_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/cnnip_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module cnnip_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_a,
  input  logic             we_a,
  input  logic [AW-1:0]    waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_a) begin
    if (we_a) mem_q[waddr_a] <= wdata_a;
  end

  assign rdata_a = mem_q[raddr_a];

endmodule

// File: rtl/cnnip_stream_fifo.sv
// Single-clock valid/ready FIFO with occupancy, threshold flags, flush and high-water mark.
module cnnip_stream_fifo
  import cnnip_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned AF_LEVEL = DEPTH - 1,
  parameter  int unsigned AE_LEVEL = 1,
  localparam int unsigned CW       = cnnip_cw(DEPTH)
) (
  input  logic             clk_a,
  input  logic             srst_aq,
  input  logic             clr_a,
  input  logic             in_valid_a,
  output logic             in_ready_a,
  input  logic [WIDTH-1:0] in_data_a,
  output logic             out_valid_a,
  input  logic             out_ready_a,
  output logic [WIDTH-1:0] out_data_a,
  output logic [CW-1:0]    count_a,
  output logic             almost_full_a,
  output logic             almost_empty_a,
  output logic [CW-1:0]    hwm_a
);

  localparam int unsigned PW = cnnip_pw(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, hwm_q, hwm_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic          push_c, pop_c;

  assign push_c = in_valid_a & in_ready_q;
  assign pop_c  = out_valid_q & out_ready_a;

  // Next state; every handshake output is registered from count_d.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    hwm_d          = hwm_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    if (clr_a) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      hwm_d          = '0;
      in_ready_d     = 1'b1;
      out_valid_d    = 1'b0;
      almost_full_d  = (AF_LEVEL == 32'd0);
      almost_empty_d = 1'b1;
    end else begin
      if (push_c) wr_ptr_d = PW'(cnnip_wrap_inc(32'(wr_ptr_q), DEPTH));
      if (pop_c)  rd_ptr_d = PW'(cnnip_wrap_inc(32'(rd_ptr_q), DEPTH));
      count_d        = count_q + CW'(push_c) - CW'(pop_c);
      in_ready_d     = (32'(count_d) != DEPTH);
      out_valid_d    = (count_d != '0);
      almost_full_d  = (32'(count_d) >= AF_LEVEL);
      almost_empty_d = (32'(count_d) <= AE_LEVEL);
      hwm_d          = (count_d > hwm_q) ? count_d : hwm_q;
    end
  end

  always_ff @(posedge clk_a) begin
    if (srst_aq) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      hwm_q          <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      almost_full_q  <= (AF_LEVEL == 32'd0);
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      hwm_q          <= hwm_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // A push coincident with a flush or reset is dropped, so it must not touch memory.
  cnnip_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_a   (clk_a),
    .we_a    (push_c & ~clr_a & ~srst_aq),
    .waddr_a (wr_ptr_q),
    .wdata_a (in_data_a),
    .raddr_a (rd_ptr_q),
    .rdata_a (out_data_a)
  );

  assign in_ready_a     = in_ready_q;
  assign out_valid_a    = out_valid_q;
  assign count_a        = count_q;
  assign almost_full_a  = almost_full_q;
  assign almost_empty_a = almost_empty_q;
  assign hwm_a          = hwm_q;

endmodule
